// File: rtl/matrix_op_defs_pkg.sv
// Shared matrix-operation types: status and mode encodings, memory layout
// constants, and the slot capacity check used by the matrix engines.
package matrix_op_defs_pkg;

    localparam int MATRIX_DATA_WIDTH     = 32;
    localparam int MATRIX_ADDR_WIDTH     = 10;
    localparam int MATRIX_BLOCK_SIZE     = 64;
    localparam int MATRIX_METADATA_WORDS = 3;

    typedef enum logic [2:0] {
        STATUS_IDLE      = 3'd0,
        STATUS_SUCCESS   = 3'd1,
        STATUS_ERR_ID    = 3'd2,
        STATUS_ERR_EMPTY = 3'd3,
        STATUS_ERR_DIM   = 3'd4,
        STATUS_ERR_MODE  = 3'd5
    } matrix_op_status_e;

    typedef enum logic [1:0] {
        MODE_COPY      = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_SCALE     = 2'd2
    } matrix_unary_mode_e;

    typedef struct packed {
        logic [7:0] rows;
        logic [7:0] cols;
    } matrix_shape_t;

    // Element count must fit in a slot after the metadata words
    function automatic logic is_data_capacity_ok(input matrix_shape_t shape, input int block_size);
        logic [15:0] elems;
        elems = 16'(shape.rows) * 16'(shape.cols);
        return int'(elems) <= (block_size - MATRIX_METADATA_WORDS);
    endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// Output-order row/column counters for the unary engine, producing the
// source element offset (row-major or transposed) and a last-element flag.
module matrix_index_gen
    import matrix_op_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        advance,
    input  logic        transpose,
    input  logic [7:0]  out_rows,
    input  logic [7:0]  out_cols,
    input  logic [7:0]  src_cols,
    output logic [15:0] src_offset,
    output logic        last
);

    logic [7:0] row_q;
    logic [7:0] col_q;
    logic       col_wrap;

    assign col_wrap = (col_q == out_cols - 8'd1);
    assign last     = col_wrap && (row_q == out_rows - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col_q <= '0;
                row_q <= row_q + 8'd1;
            end else begin
                col_q <= col_q + 8'd1;
            end
        end
    end

    // Output (r,c) of a transpose is source (c,r); source stride is always src_cols
    always_comb begin
        if (transpose)
            src_offset = 16'(col_q) * 16'(src_cols) + 16'(row_q);
        else
            src_offset = 16'(row_q) * 16'(src_cols) + 16'(col_q);
    end

endmodule

// File: rtl/matrix_op_unary.sv
// Unary matrix engine: reads a source slot, then streams COPY, TRANSPOSE or
// SCALE results to the matrix writer after validating IDs, mode and shape.
module matrix_op_unary
    import matrix_op_defs_pkg::*;
#(
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
    parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
    parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [2:0]            matrix_src_id,
    input  logic [2:0]            matrix_dst_id,
    input  logic [DATA_WIDTH-1:0] scalar,
    output logic                  busy,
    output matrix_op_status_e     status,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  write_request,
    input  logic                  write_ready,
    output logic [2:0]            matrix_id,
    output logic [7:0]            actual_rows,
    output logic [7:0]            actual_cols,
    output logic [7:0]            matrix_name [0:7],
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_valid,
    input  logic                  writer_ready,
    input  logic                  write_done
);

    typedef enum logic [3:0] {
        IDLE, CHECK_ID, READ_META, READ_META_WAIT, VALIDATE, WAIT_WRITE_READY,
        ASSERT_WRITE_REQ, WAIT_WRITER_ENABLE, PREPARE_SRC_ADDR, READ_SRC_WAIT,
        WAIT_WRITER_FOR_DATA, UPDATE_INDICES, WAIT_WRITE_DONE, DONE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q;
    logic [2:0]            src_id_q, dst_id_q;
    logic [DATA_WIDTH-1:0] scalar_q;
    logic [1:0]            meta_cnt_q;
    logic [7:0]            rows_q, cols_q;
    matrix_op_status_e     result_q;
    logic                  have_data_q;

    logic                  id_bad, mode_bad, meta_empty, meta_too_big, is_transpose;
    matrix_shape_t         src_shape;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [15:0]           src_offset;
    logic                  idx_last, idx_clear, idx_advance;
    logic [DATA_WIDTH-1:0] scaled, elem_val;

    assign id_bad       = (src_id_q == 3'd0) || (src_id_q == dst_id_q);
    assign mode_bad     = (mode_q == 2'b11);
    assign is_transpose = (mode_q == MODE_TRANSPOSE);
    assign src_shape    = {rows_q, cols_q};
    assign meta_empty   = (rows_q == 8'd0) || (cols_q == 8'd0);
    assign meta_too_big = !is_data_capacity_ok(src_shape, BLOCK_SIZE);
    assign src_base     = ADDR_WIDTH'(32'(src_id_q) * BLOCK_SIZE);
    assign scaled       = $signed(data_out) * $signed(scalar_q);
    assign elem_val     = (mode_q == MODE_SCALE) ? scaled : data_out;

    matrix_index_gen u_index_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (idx_clear),
        .advance    (idx_advance),
        .transpose  (is_transpose),
        .out_rows   (actual_rows),
        .out_cols   (actual_cols),
        .src_cols   (cols_q),
        .src_offset (src_offset),
        .last       (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        idx_clear     = 1'b0;
        idx_advance   = 1'b0;
        write_request = 1'b0;
        data_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_clear = 1'b1;
                if (start) state_d = CHECK_ID;
            end
            CHECK_ID:             state_d = (id_bad || mode_bad) ? DONE : READ_META;
            READ_META:            state_d = READ_META_WAIT;
            READ_META_WAIT:       state_d = (meta_cnt_q == 2'd2) ? VALIDATE : READ_META;
            VALIDATE:             state_d = (meta_empty || meta_too_big) ? DONE : WAIT_WRITE_READY;
            WAIT_WRITE_READY:     if (write_ready) state_d = ASSERT_WRITE_REQ;
            ASSERT_WRITE_REQ: begin
                write_request = 1'b1;
                state_d       = WAIT_WRITER_ENABLE;
            end
            WAIT_WRITER_ENABLE:   if (writer_ready) state_d = PREPARE_SRC_ADDR;
            PREPARE_SRC_ADDR:     state_d = READ_SRC_WAIT;
            READ_SRC_WAIT:        state_d = WAIT_WRITER_FOR_DATA;
            WAIT_WRITER_FOR_DATA: begin
                if (have_data_q && writer_ready) begin
                    data_valid = 1'b1;
                    state_d    = UPDATE_INDICES;
                end
            end
            UPDATE_INDICES: begin
                if (idx_last) begin
                    state_d = WAIT_WRITE_DONE;
                end else begin
                    idx_advance = 1'b1;
                    state_d     = PREPARE_SRC_ADDR;
                end
            end
            WAIT_WRITE_DONE:      if (write_done) state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Datapath: element data is captured once on arrival so data_in stays put through writer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            src_id_q    <= '0;
            dst_id_q    <= '0;
            scalar_q    <= '0;
            meta_cnt_q  <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            result_q    <= STATUS_IDLE;
            have_data_q <= 1'b0;
            busy        <= 1'b0;
            status      <= STATUS_IDLE;
            read_addr   <= '0;
            matrix_id   <= '0;
            actual_rows <= '0;
            actual_cols <= '0;
            data_in     <= '0;
            for (int i = 0; i < 8; i++) matrix_name[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        src_id_q <= matrix_src_id;
                        dst_id_q <= matrix_dst_id;
                        scalar_q <= scalar;
                        status   <= STATUS_IDLE;
                        busy     <= 1'b1;
                    end
                end
                CHECK_ID: begin
                    meta_cnt_q <= '0;
                    if (id_bad)        result_q  <= STATUS_ERR_ID;
                    else if (mode_bad) result_q  <= STATUS_ERR_MODE;
                    else               read_addr <= src_base;
                end
                READ_META_WAIT: begin
                    case (meta_cnt_q)
                        2'd0: begin
                            rows_q <= data_out[31:24];
                            cols_q <= data_out[23:16];
                        end
                        2'd1: for (int i = 0; i < 4; i++) matrix_name[i]     <= data_out[31 - 8*i -: 8];
                        default: for (int i = 0; i < 4; i++) matrix_name[i + 4] <= data_out[31 - 8*i -: 8];
                    endcase
                    if (meta_cnt_q != 2'd2) begin
                        meta_cnt_q <= meta_cnt_q + 2'd1;
                        read_addr  <= read_addr + ADDR_WIDTH'(1);
                    end
                end
                VALIDATE: begin
                    if (meta_empty) begin
                        result_q <= STATUS_ERR_EMPTY;
                    end else if (meta_too_big) begin
                        result_q <= STATUS_ERR_DIM;
                    end else begin
                        matrix_id   <= dst_id_q;
                        actual_rows <= is_transpose ? cols_q : rows_q;
                        actual_cols <= is_transpose ? rows_q : cols_q;
                    end
                end
                PREPARE_SRC_ADDR: begin
                    read_addr   <= src_base + ADDR_WIDTH'(MATRIX_METADATA_WORDS) + ADDR_WIDTH'(src_offset);
                    have_data_q <= 1'b0;
                end
                WAIT_WRITER_FOR_DATA: begin
                    if (!have_data_q) begin
                        data_in     <= elem_val;
                        have_data_q <= 1'b1;
                    end
                end
                WAIT_WRITE_DONE: if (write_done) result_q <= STATUS_SUCCESS;
                DONE: begin
                    status <= result_q;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_op_unary.sv
// Directed bench for matrix_op_unary with a slot memory and a writer model.
module tb_matrix_op_unary;
    import matrix_op_defs_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [2:0]        srcId = 3'd0;
    logic [2:0]        dstId = 3'd0;
    logic [31:0]       scalar = 32'd0;
    logic              busy;
    matrix_op_status_e status;
    logic [9:0]        read_addr;
    logic [31:0]       data_out = 32'd0;
    logic              write_request;
    logic              write_ready = 1'b1;
    logic [2:0]        matrix_id;
    logic [7:0]        actual_rows, actual_cols;
    logic [7:0]        nameBus [0:7];
    logic [31:0]       data_in;
    logic              data_valid;
    logic              writer_ready;
    logic              write_done;

    logic              toggleMode = 1'b0;
    logic              toggleReg = 1'b0;
    logic [31:0]       mem [0:511];
    logic [31:0]       capBuf [0:63];
    logic              wrActive;
    logic [6:0]        wrCount;
    int                reqCount = 0;
    int                validCount = 0;
    logic [2:0]        gotId = 3'd0;
    logic [7:0]        gotRows = 8'd0, gotCols = 8'd0;
    logic [63:0]       gotName = 64'd0;
    int                vectorCount = 0;
    int                missCount = 0;

    logic [31:0] expTr [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};

    matrix_op_unary dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .matrix_src_id(srcId), .matrix_dst_id(dstId), .scalar(scalar),
        .busy(busy), .status(status), .read_addr(read_addr), .data_out(data_out),
        .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
        .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(nameBus),
        .data_in(data_in), .data_valid(data_valid), .writer_ready(writer_ready),
        .write_done(write_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read slot memory
    always @(posedge clk) data_out <= mem[read_addr];

    always @(posedge clk) toggleReg <= ~toggleReg;
    assign writer_ready = toggleMode ? toggleReg : 1'b1;
    assign write_done   = wrActive && (16'(wrCount) == 16'(gotRows) * 16'(gotCols));

    // Writer model: records the header on write_request and collects elements
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrActive <= 1'b0;
            wrCount  <= '0;
        end else begin
            if (write_request) begin
                wrActive <= 1'b1;
                wrCount  <= '0;
                reqCount <= reqCount + 1;
                gotId    <= matrix_id;
                gotRows  <= actual_rows;
                gotCols  <= actual_cols;
                gotName  <= {nameBus[0], nameBus[1], nameBus[2], nameBus[3],
                             nameBus[4], nameBus[5], nameBus[6], nameBus[7]};
            end else if (data_valid) begin
                capBuf[wrCount[5:0]] <= data_in;
                wrCount <= wrCount + 7'd1;
            end
            if (data_valid) validCount <= validCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic loadMeta(input int slot, input logic [7:0] rows, input logic [7:0] cols,
                            input logic [31:0] w1, input logic [31:0] w2);
        mem[slot*64]     = {rows, cols, 16'h0000};
        mem[slot*64 + 1] = w1;
        mem[slot*64 + 2] = w2;
    endtask

    task automatic setElem(input int slot, input int idx, input logic [31:0] val);
        mem[slot*64 + 3 + idx] = val;
    endtask

    task automatic pulseStart(input logic [1:0] m, input logic [2:0] s, input logic [2:0] d, input logic [31:0] sc);
        @(negedge clk);
        mode = m; srcId = s; dstId = d; scalar = sc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int cycles = 0;
        while (busy && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "-timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] s, input logic [2:0] d,
                                 input logic [31:0] sc, input string tag);
        pulseStart(m, s, d, sc);
        checkOutput({tag, "-busy"}, 64'(busy), 64'd1);
        waitIdle(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqBase, validBase, cycles;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        loadMeta(1, 8'd2, 8'd3, 32'h4D415431, 32'h41424344);
        for (int i = 0; i < 6; i++) setElem(1, i, 32'(i + 1));
        loadMeta(2, 8'd3, 8'd1, 32'h5343414C, 32'h45000000);
        setElem(2, 0, 32'd7); setElem(2, 1, 32'd8); setElem(2, 2, 32'hFFFFFFF7);
        loadMeta(6, 8'd1, 8'd1, 32'h4F4E4500, 32'h00000000);
        setElem(6, 0, 32'h40000000);
        loadMeta(3, 8'd2, 8'd2, 32'h434F5059, 32'h32583200);
        setElem(3, 0, 32'd10); setElem(3, 1, 32'd20); setElem(3, 2, 32'd30); setElem(3, 3, 32'd40);

        repeat (3) @(negedge clk);
        checkOutput("rst-busy", 64'(busy), 64'd0);
        checkOutput("rst-status", 64'(status), 64'(STATUS_IDLE));
        checkOutput("rst-addr", 64'(read_addr), 64'd0);
        checkOutput("rst-wreq", 64'(write_request), 64'd0);
        checkOutput("rst-valid", 64'(data_valid), 64'd0);
        checkOutput("rst-data", 64'(data_in), 64'd0);
        checkOutput("rst-id", 64'(matrix_id), 64'd0);
        checkOutput("rst-shape", 64'({actual_rows, actual_cols}), 64'd0);
        checkOutput("rst-name", 64'({nameBus[0], nameBus[3], nameBus[7]}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] transpose 2x3 slot1 -> slot0");
        reqBase = reqCount;
        applyStimulus(MODE_TRANSPOSE, 3'd1, 3'd0, 32'd0, "tr");
        checkOutput("tr-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("tr-reqs", 64'(reqCount - reqBase), 64'd1);
        checkOutput("tr-id", 64'(gotId), 64'd0);
        checkOutput("tr-shape", 64'({gotRows, gotCols}), 64'h0302);
        checkOutput("tr-name", gotName, 64'h4D41543141424344);
        checkOutput("tr-count", 64'(wrCount), 64'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("tr-elem%0d", i), 64'(capBuf[i]), 64'(expTr[i]));

        $display("[TB] scale 3x1 by -2 slot2 -> slot4");
        applyStimulus(MODE_SCALE, 3'd2, 3'd4, 32'hFFFFFFFE, "sc");
        checkOutput("sc-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("sc-id", 64'(gotId), 64'd4);
        checkOutput("sc-shape", 64'({gotRows, gotCols}), 64'h0301);
        checkOutput("sc-elem0", 64'(capBuf[0]), 64'hFFFFFFF2);
        checkOutput("sc-elem1", 64'(capBuf[1]), 64'hFFFFFFF0);
        checkOutput("sc-elem2", 64'(capBuf[2]), 64'h00000012);
        applyStimulus(MODE_SCALE, 3'd6, 3'd7, 32'd4, "sc1");
        checkOutput("sc1-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("sc1-count", 64'(wrCount), 64'd1);
        checkOutput("sc1-wrap", 64'(capBuf[0]), 64'd0);

        $display("[TB] copy 2x2 with writer_ready toggling");
        toggleMode = 1'b1;
        validBase = validCount;
        applyStimulus(MODE_COPY, 3'd3, 3'd1, 32'd0, "cp");
        toggleMode = 1'b0;
        checkOutput("cp-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("cp-pulses", 64'(validCount - validBase), 64'd4);
        checkOutput("cp-elems", {capBuf[0][15:0], capBuf[1][15:0], capBuf[2][15:0], capBuf[3][15:0]},
                    64'h000A0014001E0028);

        $display("[TB] error cases");
        reqBase = reqCount;
        mem[3*64] = 32'd0;
        applyStimulus(MODE_COPY, 3'd3, 3'd1, 32'd0, "empty");
        checkOutput("empty-status", 64'(status), 64'(STATUS_ERR_EMPTY));
        applyStimulus(MODE_COPY, 3'd0, 3'd1, 32'd0, "src0");
        checkOutput("src0-status", 64'(status), 64'(STATUS_ERR_ID));
        applyStimulus(MODE_COPY, 3'd5, 3'd5, 32'd0, "same");
        checkOutput("same-status", 64'(status), 64'(STATUS_ERR_ID));
        applyStimulus(2'b11, 3'd1, 3'd2, 32'd0, "mode3");
        checkOutput("mode3-status", 64'(status), 64'(STATUS_ERR_MODE));
        loadMeta(5, 8'd31, 8'd2, 32'd0, 32'd0);
        applyStimulus(MODE_COPY, 3'd5, 3'd6, 32'd0, "dim");
        checkOutput("dim-status", 64'(status), 64'(STATUS_ERR_DIM));
        checkOutput("err-reqs", 64'(reqCount - reqBase), 64'd0);

        $display("[TB] largest fitting shape 61x1");
        loadMeta(5, 8'd61, 8'd1, 32'd0, 32'd0);
        for (int i = 0; i < 61; i++) setElem(5, i, 32'(i + 100));
        applyStimulus(MODE_COPY, 3'd5, 3'd6, 32'd0, "fit");
        checkOutput("fit-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("fit-count", 64'(wrCount), 64'd61);
        checkOutput("fit-last", 64'(capBuf[60]), 64'd160);

        $display("[TB] start while busy is ignored");
        reqBase = reqCount;
        pulseStart(MODE_TRANSPOSE, 3'd1, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        pulseStart(MODE_COPY, 3'd2, 3'd6, 32'd0);
        waitIdle("ign");
        checkOutput("ign-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("ign-reqs", 64'(reqCount - reqBase), 64'd1);
        checkOutput("ign-id", 64'(gotId), 64'd0);
        checkOutput("ign-elem1", 64'(capBuf[1]), 64'd4);

        $display("[TB] reset during streaming");
        toggleMode = 1'b1;
        validBase = validCount;
        pulseStart(MODE_TRANSPOSE, 3'd1, 3'd0, 32'd0);
        cycles = 0;
        while ((validCount - validBase) < 2 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("mid-reached", 64'(validCount - validBase >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-busy", 64'(busy), 64'd0);
        checkOutput("mid-valid", 64'(data_valid), 64'd0);
        checkOutput("mid-addr", 64'(read_addr), 64'd0);
        checkOutput("mid-data", 64'(data_in), 64'd0);
        checkOutput("mid-hdr", 64'({matrix_id, actual_rows, actual_cols}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        validBase = validCount;
        repeat (20) @(negedge clk);
        checkOutput("mid-quiet", 64'(validCount - validBase), 64'd0);
        toggleMode = 1'b0;
        applyStimulus(MODE_TRANSPOSE, 3'd1, 3'd0, 32'd0, "re");
        checkOutput("re-status", 64'(status), 64'(STATUS_SUCCESS));
        checkOutput("re-count", 64'(wrCount), 64'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("re-elem%0d", i), 64'(capBuf[i]), 64'(expTr[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
